// File: rtl/product_uart_tx_pkg.sv
// Shared definitions for the product UART transmitter: FSM encoding and frame constants.
package product_uart_tx_pkg;

    localparam int unsigned DATA_BITS       = 8;
    localparam int unsigned BIT_IDX_W       = $clog2(DATA_BITS);
    localparam logic        UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/baud_counter.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and pulses bit_done on the last cycle of each bit.
module baud_counter #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    output logic bit_done
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] cnt;

    assign bit_done = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (clear || bit_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/product_uart_tx.sv
// Captures multiplier products on the rising edge of tx and serialises them as UART frames.
module product_uart_tx
    import product_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [DATA_BITS-1:0] product,
    input  logic                 tx,
    output logic                 uart_txd,
    output logic                 busy,
    output logic                 overflow
);

    localparam bit HAS_PARITY = (PARITY_EN != 0);

    uart_state_e          state, state_nxt;
    logic                 tx_d;
    logic [DATA_BITS-1:0] hold_reg, hold_reg_nxt;
    logic                 hold_valid, hold_valid_nxt;
    logic [DATA_BITS-1:0] shifter, shifter_nxt;
    logic [BIT_IDX_W-1:0] bit_idx, bit_idx_nxt;
    logic                 parity_bit, parity_nxt;
    logic                 txd_nxt;
    logic                 overflow_nxt;
    logic                 capture;
    logic                 consume;
    logic                 bit_done;

    assign capture = tx & ~tx_d;
    assign busy    = (state != IDLE) | hold_valid;

    baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .CLK     (CLK),
        .RST     (RST),
        .clear   (state == IDLE),
        .bit_done(bit_done)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            tx_d       <= 1'b0;
            hold_reg   <= '0;
            hold_valid <= 1'b0;
            shifter    <= '0;
            bit_idx    <= '0;
            parity_bit <= 1'b0;
            uart_txd   <= UART_IDLE_LEVEL;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            tx_d       <= tx;
            hold_reg   <= hold_reg_nxt;
            hold_valid <= hold_valid_nxt;
            shifter    <= shifter_nxt;
            bit_idx    <= bit_idx_nxt;
            parity_bit <= parity_nxt;
            uart_txd   <= txd_nxt;
            overflow   <= overflow_nxt;
        end
    end

    // uart_txd is registered, so each branch drives the level of the state being entered
    always_comb begin
        state_nxt      = state;
        hold_reg_nxt   = hold_reg;
        hold_valid_nxt = hold_valid;
        shifter_nxt    = shifter;
        bit_idx_nxt    = bit_idx;
        parity_nxt     = parity_bit;
        txd_nxt        = uart_txd;
        overflow_nxt   = overflow;
        consume        = 1'b0;

        case (state)
            IDLE: begin
                if (hold_valid) begin
                    consume     = 1'b1;
                    shifter_nxt = hold_reg;
                    parity_nxt  = ^hold_reg;
                    bit_idx_nxt = '0;
                    txd_nxt     = ~UART_IDLE_LEVEL;
                    state_nxt   = START;
                end
            end
            START: begin
                if (bit_done) begin
                    txd_nxt   = shifter[0];
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx == BIT_IDX_W'(DATA_BITS - 1)) begin
                        txd_nxt   = HAS_PARITY ? parity_bit : UART_IDLE_LEVEL;
                        state_nxt = HAS_PARITY ? PARITY : STOP;
                    end else begin
                        shifter_nxt = shifter >> 1;
                        bit_idx_nxt = bit_idx + BIT_IDX_W'(1);
                        txd_nxt     = shifter[1];
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    txd_nxt   = UART_IDLE_LEVEL;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    txd_nxt   = UART_IDLE_LEVEL;
                    state_nxt = IDLE;
                end
            end
            default: begin
                txd_nxt   = UART_IDLE_LEVEL;
                state_nxt = IDLE;
            end
        endcase

        // A capture coinciding with consumption refills the holding register
        if (capture) begin
            if (hold_valid && !consume) begin
                overflow_nxt = 1'b1;
            end else begin
                hold_reg_nxt   = product;
                hold_valid_nxt = 1'b1;
            end
        end else if (consume) begin
            hold_valid_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_product_uart_tx.sv
// Scoreboard bench for product_uart_tx: default instance plus an even-parity instance.
module tb_product_uart_tx;

    localparam int unsigned CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] prod0 = '0, prod1 = '0;
    logic       tx0 = 1'b0, tx1 = 1'b0;
    logic       txd0, busy0, ovf0;
    logic       txd1, busy1, ovf1;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         nfr0 = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         starts0[$];
    int         ends0[$];

    product_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
        .CLK(clk), .RST(rst), .product(prod0), .tx(tx0),
        .uart_txd(txd0), .busy(busy0), .overflow(ovf0)
    );

    product_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
        .CLK(clk), .RST(rst), .product(prod1), .tx(tx1),
        .uart_txd(txd1), .busy(busy1), .overflow(ovf1)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Collects whole frames from one line, checks bit timing/framing and pops the scoreboard
    task automatic run_monitor(input bit sel);
        logic       prev = 1'b1;
        logic       cur;
        logic       s[0:43];
        logic [7:0] data;
        logic [7:0] expd;
        bit         aborted;
        int         nbits;
        int         lenbad;
        int         st;
        nbits = sel ? 11 : 10;
        forever begin
            @(negedge clk);
            cur = sel ? txd1 : txd0;
            if (!rst && prev && !cur) begin
                st      = cyc;
                s[0]    = cur;
                aborted = 1'b0;
                for (int i = 1; i < nbits * CPB; i++) begin
                    @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    s[i] = sel ? txd1 : txd0;
                end
                cur = sel ? txd1 : txd0;
                if (!aborted) begin
                    lenbad = 0;
                    for (int b = 0; b < nbits; b++)
                        for (int j = 1; j < CPB; j++)
                            if (s[b*CPB+j] !== s[b*CPB]) lenbad++;
                    for (int d = 0; d < 8; d++) data[d] = s[(1+d)*CPB];
                    check(sel ? "bit_len1" : "bit_len0", 32'(lenbad), 32'd0);
                    check(sel ? "start_bit1" : "start_bit0", 32'(s[0]), 32'd0);
                    check(sel ? "stop_bit1" : "stop_bit0", 32'(s[(nbits-1)*CPB]), 32'd1);
                    if ((sel ? q1.size() : q0.size()) == 0) begin
                        check("sb_underflow", 32'(data), 32'hFFFF_FFFF);
                        expd = data;
                    end else begin
                        expd = sel ? q1.pop_front() : q0.pop_front();
                        check(sel ? "frame_data1" : "frame_data0", 32'(data), 32'(expd));
                    end
                    if (sel) begin
                        check("parity_bit", 32'(s[9*CPB]), 32'(^expd));
                    end else begin
                        nfr0++;
                        starts0.push_back(st);
                        ends0.push_back(st + int'(nbits * CPB) - 1);
                    end
                end
            end
            prev = cur;
        end
    endtask

    initial run_monitor(1'b0);
    initial run_monitor(1'b1);

    task automatic send0(input logic [7:0] b, input bit kept);
        @(negedge clk);
        prod0 = b;
        tx0   = 1'b1;
        if (kept) q0.push_back(b);
        @(negedge clk);
        tx0 = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy0 || busy1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n >= 500), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic count_busy(input bit sel, output int cnt);
        cnt = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sel ? busy1 : busy0) cnt++;
            else break;
        end
    endtask

    initial begin : stim
        int bcnt;
        int bad;
        int f0;

        // Reset state
        #2 rst = 1'b1;
        #1;
        check("rst_txd", 32'(txd0), 32'd1);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_ovf", 32'(ovf0), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single frame: latency, frame bits, busy duration
        @(negedge clk);
        prod0 = 8'hF2;
        tx0   = 1'b1;
        q0.push_back(8'hF2);
        @(negedge clk);
        tx0   = 1'b0;
        prod0 = 8'h55;
        check("lat_k_txd", 32'(txd0), 32'd1);
        check("lat_k_busy", 32'(busy0), 32'd1);
        @(negedge clk);
        check("lat_k1_txd", 32'(txd0), 32'd0);
        count_busy(1'b0, bcnt);
        check("busy_len0", 32'(bcnt + 1), 32'd41);
        check("single_ovf", 32'(ovf0), 32'd0);
        wait_idle();

        // Queued frame: one idle cycle between stop and next start
        starts0.delete();
        ends0.delete();
        send0(8'hFE, 1'b1);
        repeat (8) @(negedge clk);
        send0(8'h01, 1'b1);
        wait_idle();
        check("queued_frames", 32'(starts0.size()), 32'd2);
        if (starts0.size() == 2)
            check("b2b_gap", 32'(starts0[1] - ends0[0]), 32'd2);
        check("queued_ovf", 32'(ovf0), 32'd0);

        // tx held high ~110 ns gives exactly one frame
        f0 = nfr0;
        @(negedge clk);
        #5;
        prod0 = 8'hF2;
        tx0   = 1'b1;
        q0.push_back(8'hF2);
        #110;
        tx0 = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk);
        check("held_tx_frames", 32'(nfr0 - f0), 32'd1);

        // Overflow: third capture inside the first frame is dropped
        f0 = nfr0;
        send0(8'hF2, 1'b1);
        repeat (3) @(negedge clk);
        send0(8'hFE, 1'b1);
        repeat (3) @(negedge clk);
        send0(8'h01, 1'b0);
        @(negedge clk);
        check("ovf_set", 32'(ovf0), 32'd1);
        wait_idle();
        check("ovf_frames", 32'(nfr0 - f0), 32'd2);
        check("ovf_sticky", 32'(ovf0), 32'd1);

        // Parity instance: 8'h07 -> parity 1, 44-cycle frame
        @(negedge clk);
        prod1 = 8'h07;
        tx1   = 1'b1;
        q1.push_back(8'h07);
        @(negedge clk);
        tx1 = 1'b0;
        count_busy(1'b1, bcnt);
        check("busy_len1", 32'(bcnt), 32'd45);
        wait_idle();

        // Reset mid-frame aborts immediately and clears overflow
        send0(8'hF2, 1'b0);
        repeat (15) @(negedge clk);
        check("pre_rst_ovf", 32'(ovf0), 32'd1);
        #5 rst = 1'b1;
        #1;
        check("midrst_txd", 32'(txd0), 32'd1);
        check("midrst_busy", 32'(busy0), 32'd0);
        check("midrst_ovf", 32'(ovf0), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (txd0 !== 1'b1 || busy0 !== 1'b0 || ovf0 !== 1'b0) bad++;
        end
        check("post_rst_quiet", 32'(bad), 32'd0);

        check("sb_empty0", 32'(q0.size()), 32'd0);
        check("sb_empty1", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
